// File: rtl/typing_stats.sv
// typing_stats: per-race keystroke/time statistics with a shared divider.
//
// While a race runs, counts correct keys, total keys and 0.1 s ticks. When
// the race ends, one restoring divider (18 cycles per division) computes
// words-per-minute and then accuracy. The two results are presented together
// with a single-cycle finish pulse.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tick         one-cycle pulse every 0.1 s (free-running)
//   start        one-cycle pulse: begin (or restart) a race
//   key_valid    one-cycle pulse per typed character
//   key_correct  qualifies key_valid: character matched the target
//   done         one-cycle pulse: last target character typed
//   wpm          words per minute of the last race, 0..WPM_MAX
//   acc          accuracy percent of the last race, 0..100
//   finish       one-cycle pulse: wpm/acc newly valid
//   busy         race running or results being computed
//   elapsed      tick count of the current/last race
module typing_stats #(
    parameter int CHARS_PER_WORD = 5,
    parameter int TICKS_PER_MIN  = 600,
    parameter int WPM_MAX        = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        key_valid,
    input  logic        key_correct,
    input  logic        done,
    output logic [9:0]  wpm,
    output logic [9:0]  acc,
    output logic        finish,
    output logic        busy,
    output logic [15:0] elapsed
);

    localparam logic [17:0] WPM_SCALE = 18'(TICKS_PER_MIN / CHARS_PER_WORD);
    localparam logic [17:0] ACC_SCALE = 18'd100;
    localparam logic [4:0]  LAST_STEP = 5'd17;

    typedef enum logic [2:0] {IDLE, RUN, DIV_WPM, DIV_ACC, DONE} state_t;

    state_t      state, state_next;

    logic [9:0]  correct_cnt, total_cnt;
    logic [9:0]  correct_nxt, total_nxt;
    logic [15:0] elapsed_nxt;

    // Divider registers: dvd shifts the dividend out and the quotient in.
    logic [17:0] dvd;
    logic [15:0] dvs;
    logic [15:0] rem;
    logic [4:0]  step_cnt;
    logic        step_last;
    logic        acc_zero;
    logic [9:0]  wpm_hold;

    logic [16:0] shifted;
    logic        ge;
    logic [15:0] rem_step;
    logic [17:0] quot_step;

    logic [17:0] wpm_dividend, acc_dividend;
    logic [15:0] wpm_divisor, acc_divisor;

    function automatic logic [9:0] sat_wpm(input logic [17:0] q);
        if (q > 18'(WPM_MAX)) return 10'(WPM_MAX);
        return q[9:0];
    endfunction

    // Counter values after this edge's keys/tick; used so that activity on
    // the same edge as done is included in the WPM operands.
    assign correct_nxt = correct_cnt +
        {9'd0, key_valid && key_correct && (correct_cnt != 10'h3FF)};
    assign total_nxt   = total_cnt + {9'd0, key_valid && (total_cnt != 10'h3FF)};
    assign elapsed_nxt = elapsed + {15'd0, tick && (elapsed != 16'hFFFF)};

    assign wpm_dividend = 18'(correct_nxt) * WPM_SCALE;
    assign wpm_divisor  = (elapsed_nxt == 16'd0) ? 16'd1 : elapsed_nxt;
    assign acc_dividend = 18'(correct_cnt) * ACC_SCALE;
    // A zero key count still runs the divider (fixed latency) against 1.
    assign acc_divisor  = (total_cnt == 10'd0) ? 16'd1 : {6'd0, total_cnt};

    // One restoring step. The remainder stays below the divisor, so the
    // low 16 bits of the subtraction are exact whenever ge is set.
    assign shifted   = {rem, dvd[17]};
    assign ge        = (shifted >= {1'b0, dvs});
    assign rem_step  = ge ? (shifted[15:0] - dvs) : shifted[15:0];
    assign quot_step = {dvd[16:0], ge};
    assign step_last = (step_cnt == LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (!start && done) state_next = DIV_WPM;
            DIV_WPM: if (step_last) state_next = DIV_ACC;
            DIV_ACC: if (step_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign finish = (state == DONE);
    assign busy   = (state == RUN) || (state == DIV_WPM) || (state == DIV_ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            correct_cnt <= '0;
            total_cnt   <= '0;
            elapsed     <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            step_cnt    <= '0;
            acc_zero    <= 1'b0;
            wpm_hold    <= '0;
            wpm         <= '0;
            acc         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        correct_cnt <= '0;
                        total_cnt   <= '0;
                        elapsed     <= '0;
                    end
                end
                RUN: begin
                    if (start) begin
                        correct_cnt <= '0;
                        total_cnt   <= '0;
                        elapsed     <= '0;
                    end else begin
                        correct_cnt <= correct_nxt;
                        total_cnt   <= total_nxt;
                        elapsed     <= elapsed_nxt;
                        if (done) begin
                            dvd      <= wpm_dividend;
                            dvs      <= wpm_divisor;
                            rem      <= '0;
                            step_cnt <= '0;
                        end
                    end
                end
                DIV_WPM: begin
                    dvd      <= quot_step;
                    rem      <= rem_step;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_last) begin
                        // WPM quotient complete; reload for accuracy.
                        wpm_hold <= sat_wpm(quot_step);
                        dvd      <= acc_dividend;
                        dvs      <= acc_divisor;
                        acc_zero <= (total_cnt == 10'd0);
                        rem      <= '0;
                        step_cnt <= '0;
                    end
                end
                DIV_ACC: begin
                    dvd      <= quot_step;
                    rem      <= rem_step;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_last) begin
                        wpm <= wpm_hold;
                        acc <= acc_zero ? 10'd0 : quot_step[9:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/typing_stats.md
Name: typing_stats

Overview:
- Upstream producer of per-race results for the statistics/record stage.
- Counts correct and total keystrokes and elapsed time while a race runs.
- When the race ends, computes words-per-minute and accuracy with a shared iterative divider, then presents wpm/acc with a one-cycle finish pulse.
- Downstream record logic consumes wpm, acc and finish directly.

Parameters:
- CHARS_PER_WORD, 5, characters per word in the WPM formula.
- TICKS_PER_MIN, 600, number of tick pulses per minute (tick = 0.1 s).
- WPM_MAX, 999, saturation value for the wpm output.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle pulse every 0.1 s, free-running
- start  in  1  one-cycle pulse that begins a race
- key_valid  in  1  one-cycle pulse per typed character
- key_correct  in  1  qualifies key_valid; 1 = character matched target
- done  in  1  one-cycle pulse when the last target character is typed
- wpm  out  10  words per minute of last race, 0..WPM_MAX
- acc  out  10  accuracy percent of last race, 0..100
- finish  out  1  one-cycle pulse: wpm/acc newly valid
- busy  out  1  high in RUN, DIV_WPM and DIV_ACC
- elapsed  out  16  tick count of current/last race

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, divider cleared.
- States: IDLE, RUN, DIV_WPM, DIV_ACC, DONE.
- IDLE: start -> RUN; correct_cnt, total_cnt and elapsed cleared on that edge. Keys, tick and done are ignored.
- RUN, per edge:
  - tick increments elapsed; elapsed saturates at 65535.
  - key_valid increments total_cnt; key_valid&key_correct also increments correct_cnt. Both 10-bit, saturate at 1023.
  - start in RUN restarts the race: counters cleared, stay in RUN. start has priority over done.
  - done -> DIV_WPM. Keys and tick on the same edge as done are counted before the divider operands are formed.
- Divider: restoring, 18-bit dividend, 16-bit divisor, one quotient bit per cycle, exactly 18 cycles per division.
- DIV_WPM:
  - Dividend = correct_cnt * (TICKS_PER_MIN / CHARS_PER_WORD) = correct_cnt*120, 17 bits, zero-extended to 18.
  - Divisor = elapsed; elapsed==0 uses divisor 1.
  - Quotient > WPM_MAX saturates to WPM_MAX.
- DIV_ACC:
  - Dividend = correct_cnt*100; divisor = total_cnt.
  - total_cnt==0 forces result 0; the divider still takes 18 cycles, so latency is fixed.
- Timing, with done sampled at edge k:
  - Operands for DIV_WPM are loaded at edge k.
  - DIV_ACC operands are loaded at edge k+18.
  - wpm and acc registers update at edge k+36 and state -> DONE; finish=1 for that cycle only.
  - Edge k+37 -> IDLE.
- wpm/acc hold their value until the next DONE; they are not cleared by start.
- start, key_valid, tick and done are ignored in DIV_WPM, DIV_ACC and DONE.
- Rounding: quotients truncate (floor).
- rst at any point, including mid-division, returns every register to its reset value immediately. No finish pulse is produced for the aborted race.
- finish never asserts on two consecutive cycles; busy=0 whenever finish=1.

Test Plan:
- Reset, then start; 50 correct keys; 100 ticks; done -> finish exactly 36 cycles after done edge, wpm=60, acc=100, elapsed=100.
- 45 correct + 5 incorrect keys over 200 ticks, then done -> wpm=27, acc=90; busy high from start through the finish edge.
- start, then done with no keys and no ticks -> wpm=0, acc=0, finish pulses once, no X or divide fault.
- 1000 correct keys over 10 ticks -> wpm=999 (saturated), acc=100; 1100 keys -> correct_cnt holds at 1023.
- Assert rst 10 cycles into DIV_WPM -> all outputs 0 next cycle, no finish. A new race afterwards of 30 correct keys over 60 ticks -> wpm=60.
- done on the same edge as key_valid&key_correct and tick: 9 prior correct keys + 1 on that edge = 10 correct, 19 prior ticks + 1 = 20 ticks -> wpm=60. A start pulse during DIV_ACC is ignored, and finish still occurs at +36.
